// File: rtl/sat_sweep_scheduler_pkg.sv
// Shared types and constants for the CNF sweep scheduler and its result table.
// Holds the FSM encoding, the formula/assignment counts and the status colours.
package sat_sweep_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_FORMULAS = 4;
  localparam int NUM_ASSIGN   = 8;

  localparam logic [2:0] RGB_OFF   = 3'b000;
  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_RED   = 3'b100;

  // Status colour: blue while sweeping, then green/red for a finished entry.
  function automatic logic [2:0] rgb_status(input logic busy, input logic valid, input logic sat);
    if (busy)
      return RGB_BLUE;
    else if (valid)
      return sat ? RGB_GREEN : RGB_RED;
    else
      return RGB_OFF;
  endfunction

endpackage

// File: rtl/sat_sweep_scheduler_result_table.sv
// Per-formula result register file: solution count, first solution, found and valid flags.
// Entries are cleared individually or all at once; reads are combinational.
module sat_result_table
  import sat_sweep_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_all,
  input  logic       clr_en,
  input  logic [1:0] clr_idx,
  input  logic       upd_en,
  input  logic [1:0] upd_idx,
  input  logic       upd_hit,
  input  logic [2:0] upd_assign,
  input  logic       set_valid,
  input  logic [1:0] rd_sel,
  output logic [3:0] rd_count,
  output logic [2:0] rd_first,
  output logic       rd_valid
);

  logic [3:0] count_reg [NUM_FORMULAS];
  logic [2:0] first_reg [NUM_FORMULAS];
  logic       found_reg [NUM_FORMULAS];
  logic       valid_reg [NUM_FORMULAS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FORMULAS; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count_reg[gi] <= '0;
          first_reg[gi] <= '0;
          found_reg[gi] <= 1'b0;
          valid_reg[gi] <= 1'b0;
        end else if (clr_all || (clr_en && clr_idx == 2'(gi))) begin
          count_reg[gi] <= '0;
          first_reg[gi] <= '0;
          found_reg[gi] <= 1'b0;
          valid_reg[gi] <= 1'b0;
        end else if (upd_en && upd_idx == 2'(gi)) begin
          if (upd_hit) begin
            count_reg[gi] <= count_reg[gi] + 4'd1;
            // Assignments are swept in ascending order, so the first hit is the lowest.
            if (!found_reg[gi]) begin
              first_reg[gi] <= upd_assign;
              found_reg[gi] <= 1'b1;
            end
          end
          if (set_valid)
            valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign rd_count = count_reg[rd_sel];
  assign rd_first = first_reg[rd_sel];
  assign rd_valid = valid_reg[rd_sel];

endmodule

// File: rtl/sat_sweep_scheduler.sv
// Sweeps all eight A/B/C assignments through the shared CNF evaluator for one or all
// formulas, recording per-formula results and driving the RGB/LED status.
module sat_sweep_scheduler
  import sat_sweep_scheduler_pkg::*;
#(
  parameter int STEP_CYCLES = 1,
  parameter int STEP_W      = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       all_mode,
  input  logic       abort,
  input  logic [1:0] sel_in,
  input  logic       cnf_in,
  output logic [1:0] cnf_sel,
  output logic [2:0] asgn,
  output logic       busy,
  output logic       done,
  input  logic [1:0] rd_sel,
  output logic [3:0] rd_count,
  output logic [2:0] rd_first,
  output logic       rd_sat,
  output logic       rd_valid,
  output logic [2:0] RGB,
  output logic [2:0] LED
);

  localparam logic [STEP_W-1:0] HOLD_LAST   = STEP_W'(STEP_CYCLES - 1);
  localparam logic [2:0]        ASSIGN_LAST = 3'(NUM_ASSIGN - 1);
  localparam logic [1:0]        SEL_LAST    = 2'(NUM_FORMULAS - 1);

  state_t            state_reg;
  logic [STEP_W-1:0] hold_cnt_reg;
  logic              all_mode_reg;

  logic launch;
  logic sample;
  logic last_assign;

  // abort gates the table strobes so an aborted entry never picks up a sample.
  assign launch      = (state_reg == IDLE) && start && !abort;
  assign sample      = (state_reg == EVAL) && (hold_cnt_reg == HOLD_LAST) && !abort;
  assign last_assign = (asgn == ASSIGN_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      all_mode_reg <= 1'b0;
      cnf_sel      <= '0;
      asgn         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (abort) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_reg    <= EVAL;
            cnf_sel      <= all_mode ? 2'd0 : sel_in;
            all_mode_reg <= all_mode;
            asgn         <= '0;
            hold_cnt_reg <= '0;
            busy         <= 1'b1;
          end
        end
        EVAL: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            hold_cnt_reg <= '0;
            if (!last_assign) begin
              asgn <= asgn + 3'd1;
            end else if (all_mode_reg && cnf_sel != SEL_LAST) begin
              cnf_sel <= cnf_sel + 2'd1;
              asgn    <= '0;
            end else begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end else begin
            hold_cnt_reg <= hold_cnt_reg + STEP_W'(1);
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  sat_result_table u_table (
    .clk        (clk),
    .reset      (reset),
    .clr_all    (launch && all_mode),
    .clr_en     (launch),
    .clr_idx    (sel_in),
    .upd_en     (sample),
    .upd_idx    (cnf_sel),
    .upd_hit    (cnf_in),
    .upd_assign (asgn),
    .set_valid  (last_assign),
    .rd_sel     (rd_sel),
    .rd_count   (rd_count),
    .rd_first   (rd_first),
    .rd_valid   (rd_valid)
  );

  assign rd_sat = (rd_count != 4'd0);
  assign RGB    = rgb_status(busy, rd_valid, rd_sat);
  assign LED    = busy ? asgn : rd_first;

endmodule

// File: tb/tb_sat_sweep_scheduler.sv
// Directed bench for sat_sweep_scheduler: single/all sweeps, abort, ignored starts,
// multi-cycle hold sampling and asynchronous reset, with an inline CNF evaluator model.
module tb_sat_sweep_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic model_all = 1'b0;

  // Instance with one-cycle steps
  logic       start1 = 0, all_mode1 = 0, abort1 = 0;
  logic [1:0] sel_in1 = 0, rd_sel1 = 0, cnf_sel1;
  logic       cnf_in1, busy1, done1, rd_sat1, rd_valid1;
  logic [2:0] asgn1, rd_first1, rgb1, led1;
  logic [3:0] rd_count1;

  // Instance with three-cycle steps
  logic       start3 = 0, all_mode3 = 0, abort3 = 0, cnf_in3 = 0;
  logic [1:0] sel_in3 = 0, rd_sel3 = 0, cnf_sel3;
  logic       busy3, done3, rd_sat3, rd_valid3;
  logic [2:0] asgn3, rd_first3, rgb3, led3;
  logic [3:0] rd_count3;

  sat_sweep_scheduler #(.STEP_CYCLES(1), .STEP_W(25)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .all_mode(all_mode1), .abort(abort1),
    .sel_in(sel_in1), .cnf_in(cnf_in1), .cnf_sel(cnf_sel1), .asgn(asgn1),
    .busy(busy1), .done(done1), .rd_sel(rd_sel1), .rd_count(rd_count1),
    .rd_first(rd_first1), .rd_sat(rd_sat1), .rd_valid(rd_valid1), .RGB(rgb1), .LED(led1)
  );

  sat_sweep_scheduler #(.STEP_CYCLES(3), .STEP_W(4)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .all_mode(all_mode3), .abort(abort3),
    .sel_in(sel_in3), .cnf_in(cnf_in3), .cnf_sel(cnf_sel3), .asgn(asgn3),
    .busy(busy3), .done(done3), .rd_sel(rd_sel3), .rd_count(rd_count3),
    .rd_first(rd_first3), .rd_sat(rd_sat3), .rd_valid(rd_valid3), .RGB(rgb3), .LED(led3)
  );

  // Evaluator model: set 0 makes every formula A&B; set 1 uses four distinct formulas.
  function automatic logic eval_model(input logic all_set, input logic [1:0] s, input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    if (!all_set) return a & b;
    case (s)
      2'd0:    return a | b | c;
      2'd1:    return 1'b0;
      2'd2:    return a ^ c;
      default: return !a & !b & !c;
    endcase
  endfunction

  assign cnf_in1 = eval_model(model_all, cnf_sel1, asgn1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if ({busy1, done1, cnf_sel1, asgn1, rd_valid1, rgb1, led1} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: got %h required 0", {busy1, done1, cnf_sel1, asgn1, rd_valid1, rgb1, led1});
    end
    reset = 1'b1;
    tick();
    $display("[TB] reset: outputs cleared");
  endtask

  task automatic test_single();
    model_all = 1'b0; sel_in1 = 2'd2; all_mode1 = 1'b0; rd_sel1 = 2'd2;
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if ({busy1, asgn1} !== {1'b1, 3'(k)}) begin
        tests_failed++;
        $display("FAIL single_step%0d: busy/assign %b/%0d required 1/%0d", k, busy1, asgn1, k);
      end
      tick();
    end
    tests_run++;
    if ({done1, busy1} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_done: done/busy %b%b required 10", done1, busy1);
    end
    tick();
    tests_run++;
    if (done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done_pulse: done %b required 0", done1);
    end
    tests_run++;
    if ({rd_count1, rd_first1, rd_sat1, rd_valid1, rgb1, led1} !== {4'd2, 3'd6, 1'b1, 1'b1, 3'b010, 3'd6}) begin
      tests_failed++;
      $display("FAIL single_table: count %0d first %0d sat %b valid %b rgb %b led %0d required 2 6 1 1 010 6",
               rd_count1, rd_first1, rd_sat1, rd_valid1, rgb1, led1);
    end
    $display("[TB] single sweep sel=2: count=%0d first=%0d", rd_count1, rd_first1);
  endtask

  task automatic test_all();
    logic [3:0] exp_cnt [4];
    logic [2:0] exp_first [4];
    exp_cnt = '{4'd7, 4'd0, 4'd4, 4'd1};
    exp_first = '{3'd1, 3'd0, 3'd1, 3'd0};
    model_all = 1'b1; all_mode1 = 1'b1;
    start1 = 1'b1; tick(); start1 = 1'b0; all_mode1 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tests_run++;
      if ({busy1, cnf_sel1, asgn1} !== {1'b1, 5'(i)}) begin
        tests_failed++;
        $display("FAIL all_step%0d: busy/sel/assign %b/%0d/%0d required 1/%0d/%0d", i, busy1, cnf_sel1, asgn1, i / 8, i % 8);
      end
      tick();
    end
    tests_run++;
    if (done1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL all_done: done %b required 1", done1);
    end
    tick();
    for (int s = 0; s < 4; s++) begin
      rd_sel1 = 2'(s);
      #1;
      tests_run++;
      if ({rd_count1, rd_first1, rd_valid1, rgb1} !== {exp_cnt[s], exp_first[s], 1'b1, (exp_cnt[s] != 0) ? 3'b010 : 3'b100}) begin
        tests_failed++;
        $display("FAIL all_table%0d: count %0d first %0d valid %b rgb %b required %0d %0d 1 %b",
                 s, rd_count1, rd_first1, rd_valid1, rgb1, exp_cnt[s], exp_first[s], (exp_cnt[s] != 0) ? 3'b010 : 3'b100);
      end
      $display("[TB] all sweep f%0d: count=%0d first=%0d rgb=%b", s, rd_count1, rd_first1, rgb1);
    end
  endtask

  task automatic test_abort();
    model_all = 1'b1; all_mode1 = 1'b1;
    start1 = 1'b1; tick(); start1 = 1'b0; all_mode1 = 1'b0;
    repeat (11) tick();
    tests_run++;
    if ({cnf_sel1, asgn1} !== {2'd1, 3'd3}) begin
      tests_failed++;
      $display("FAIL abort_position: sel/assign %0d/%0d required 1/3", cnf_sel1, asgn1);
    end
    abort1 = 1'b1; tick(); abort1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({busy1, done1} !== 2'b00) begin
        tests_failed++;
        $display("FAIL abort_idle%0d: busy/done %b%b required 00", i, busy1, done1);
      end
      tick();
    end
    rd_sel1 = 2'd0; #1;
    tests_run++;
    if ({rd_valid1, rd_count1} !== {1'b1, 4'd7}) begin
      tests_failed++;
      $display("FAIL abort_entry0: valid %b count %0d required 1 7", rd_valid1, rd_count1);
    end
    for (int s = 1; s < 4; s++) begin
      rd_sel1 = 2'(s); #1;
      tests_run++;
      if ({rd_valid1, rgb1} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL abort_entry%0d: valid %b rgb %b required 0 000", s, rd_valid1, rgb1);
      end
    end
    $display("[TB] abort at sel=1 assign=3: entry0 kept, entries 1-3 invalid");
  endtask

  task automatic test_start_ignored();
    int n;
    model_all = 1'b0; sel_in1 = 2'd2; all_mode1 = 1'b0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick(); tick();
    start1 = 1'b1; all_mode1 = 1'b1; sel_in1 = 2'd0;
    tick();
    start1 = 1'b0; all_mode1 = 1'b0;
    tests_run++;
    if ({busy1, cnf_sel1, asgn1} !== {1'b1, 2'd2, 3'd3}) begin
      tests_failed++;
      $display("FAIL busy_start: busy/sel/assign %b/%0d/%0d required 1/2/3", busy1, cnf_sel1, asgn1);
    end
    n = 0;
    while (done1 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (n != 5) begin
      tests_failed++;
      $display("FAIL busy_start_latency: %0d extra cycles required 5", n);
    end
    tick();
    rd_sel1 = 2'd0; #1;
    tests_run++;
    if ({rd_valid1, rd_count1} !== {1'b1, 4'd7}) begin
      tests_failed++;
      $display("FAIL busy_start_entry0: valid %b count %0d required 1 7", rd_valid1, rd_count1);
    end
    start1 = 1'b1; abort1 = 1'b1; tick(); start1 = 1'b0; abort1 = 1'b0;
    tests_run++;
    if (busy1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_abort: busy %b required 0", busy1);
    end
    tick();
    tests_run++;
    if ({busy1, done1} !== 2'b00) begin
      tests_failed++;
      $display("FAIL start_abort_after: busy/done %b%b required 00", busy1, done1);
    end
    $display("[TB] start during busy and start+abort ignored");
  endtask

  task automatic test_step3();
    logic ab;
    sel_in3 = 2'd2; all_mode3 = 1'b0; rd_sel3 = 2'd2;
    start3 = 1'b1; tick(); start3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ab = (k >= 6);
      for (int p = 0; p < 3; p++) begin
        cnf_in3 = (p == 2) ? ab : !ab;
        tests_run++;
        if ({busy3, asgn3} !== {1'b1, 3'(k)}) begin
          tests_failed++;
          $display("FAIL step3_hold%0d_%0d: busy/assign %b/%0d required 1/%0d", k, p, busy3, asgn3, k);
        end
        tick();
      end
    end
    cnf_in3 = 1'b0;
    tests_run++;
    if (done3 !== 1'b1) begin
      tests_failed++;
      $display("FAIL step3_done: done %b required 1", done3);
    end
    tick();
    tests_run++;
    if ({rd_count3, rd_first3, rd_valid3} !== {4'd2, 3'd6, 1'b1}) begin
      tests_failed++;
      $display("FAIL step3_table: count %0d first %0d valid %b required 2 6 1", rd_count3, rd_first3, rd_valid3);
    end
    $display("[TB] step3 sweep sel=2: count=%0d first=%0d", rd_count3, rd_first3);
  endtask

  task automatic test_reset_mid();
    model_all = 1'b0; sel_in1 = 2'd2; all_mode1 = 1'b0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (5) tick();
    tests_run++;
    if (asgn1 !== 3'd5) begin
      tests_failed++;
      $display("FAIL reset_mid_pos: assign %0d required 5", asgn1);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({busy1, done1, cnf_sel1, asgn1, rgb1} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got %b required 0", {busy1, done1, cnf_sel1, asgn1, rgb1});
    end
    for (int s = 0; s < 4; s++) begin
      rd_sel1 = 2'(s); #1;
      tests_run++;
      if ({rd_valid1, rd_count1, led1} !== 8'd0) begin
        tests_failed++;
        $display("FAIL reset_mid_entry%0d: valid %b count %0d led %0d required 0", s, rd_valid1, rd_count1, led1);
      end
    end
    tests_run++;
    if (rd_valid3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_step3: valid %b required 0", rd_valid3);
    end
    reset = 1'b1;
    tick();
    $display("[TB] reset mid-sweep: table cleared");
  endtask

  initial begin
    test_reset();
    test_single();
    test_all();
    test_abort();
    test_start_ignored();
    test_step3();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sat_sweep_scheduler.md
Name: sat_sweep_scheduler

Overview:
Sequencer that owns the shared CNF evaluator. It drives the formula select and the 3-bit A/B/C assignment, and sweeps all 8 assignments for one formula or for all 4 formulas. It samples the evaluator's combinational result and builds a per-formula result table: solution count, first solution found, and satisfiable flag. The table can be read back through a select port and drives the RGB/LED status. It sits beside the CNF evaluator in the top level and replaces the free-running solver counter when a systematic sweep is needed.

Parameters:
STEP_CYCLES, 1, cycles each assignment is held before sampling; must be ≥1 (e.g. 25_000_000 for visible stepping on the board).
STEP_W, 25, width of the hold counter; must satisfy 2^STEP_W ≥ STEP_CYCLES.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
start  input  1  single-cycle start request; honoured only in IDLE.
all_mode  input  1  sampled with start: 1 = sweep formulas 0..3, 0 = sweep only sel_in.
abort  input  1  return to IDLE; has priority over every other input.
sel_in  input  2  formula to sweep when all_mode=0.
cnf_in  input  1  combinational evaluator result for the current cnf_sel/assign.
cnf_sel  output  2  formula select to the evaluator.
assign  output  3  assignment to the evaluator: [2]=A, [1]=B, [0]=C.
busy  output  1  high in EVAL.
done  output  1  one-cycle pulse in DONE.
rd_sel  input  2  result-table read index.
rd_count  output  4  number of satisfying assignments (0..8) for formula rd_sel.
rd_first  output  3  lowest satisfying assignment; 0 if none.
rd_sat  output  1  rd_count != 0.
rd_valid  output  1  entry for rd_sel is from a completed sweep.
RGB  output  3  {R,G,B} status for formula rd_sel.
LED  output  3  mirrors assign while busy, rd_first otherwise.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. cnf_sel, assign, hold counter and all table entries (count, first, found, valid) cleared. busy=0, done=0.
- States: IDLE, EVAL, DONE. The FSM is registered; all outputs are registered except the rd_* reads and RGB/LED, which decode registered state combinationally.
- IDLE → EVAL when start=1 and abort=0:
  - cnf_sel is loaded with 0 if all_mode=1, otherwise sel_in. all_mode is latched.
  - assign and the hold counter are cleared.
  - The entries being swept (all 4, or only sel_in) are cleared, including their valid bit. Other entries are untouched.
- EVAL:
  - The hold counter counts 0..STEP_CYCLES-1. On the clock edge where it equals STEP_CYCLES-1, cnf_in is sampled.
  - On a sample with cnf_in=1: count[cnf_sel] increments (4-bit, cannot overflow; max 8). If found[cnf_sel]=0, then first[cnf_sel]=assign and found is set.
  - After sampling with assign<7: assign increments and the counter resets.
  - After sampling with assign==7: valid[cnf_sel] is set. Then, if all_mode=1 and cnf_sel<3: cnf_sel increments and assign=0, staying in EVAL. Otherwise the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. cnf_sel and assign hold their last values.
- Latency with STEP_CYCLES=1:
  - Single mode: done is high in the cycle after the 9th edge counted from the edge that sampled start.
  - All mode: done is high after the 33rd edge.
  - General case: 1 + N·8·STEP_CYCLES edges, where N is 1 or 4.
- abort (any state): next state is IDLE and the hold counter is cleared. The entry in progress keeps valid=0 (its partial count is undefined for readers). Completed entries keep their valid bit. done is not pulsed.
- start while busy: ignored. start and abort in the same cycle: abort wins.
- RGB:
  - busy: 3'b001 (blue).
  - Otherwise, rd_valid & rd_sat: 3'b010 (green).
  - Otherwise, rd_valid & !rd_sat: 3'b100 (red).
  - Otherwise: 3'b000.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, EVAL=2'd1, DONE=2'd2), NUM_FORMULAS=4, NUM_ASSIGN=8, RGB colour constants.
- One natural sub-module: sat_result_table, a 4-entry register file holding count/first/found/valid. It has clear-entry, clear-all and sample-update ports and a combinational read port.

Test Plan:
- Reset mid-sweep: assert reset=0 while assign=5 → all outputs 0 immediately, table invalid, RGB=000.
- Single mode, sel_in=2, STEP_CYCLES=1, bench model cnf_in=A&B → assign steps 0..7 one per cycle, done 9 cycles after start. Read rd_sel=2: count=2, first=6, sat=1, valid=1, RGB=010.
- All mode; bench model: f0=A|B|C, f1=constant 0, f2=A^C, f3=!A&!B&!C → done after 33 cycles. Expected counts/firsts: 7/1, 0/0 (RGB=100), 4/1, 1/0.
- abort in EVAL at cnf_sel=1, assign=3 → IDLE next cycle, no done pulse. Entry 0 remains valid; entry 1 valid=0; entries 2 and 3 are valid=0 (cleared at start).
- start pulsed during busy, plus start & abort in the same IDLE cycle → no effect in either case; busy stays as it was.
- STEP_CYCLES=3 → each assign value held exactly 3 cycles. cnf_in toggled during the non-sample cycles is ignored; only the 3rd-cycle value is counted.
